// File: rtl/ispm_loader.sv
// Boot/debug initiator that streams 64-bit words into instruction SPM or dumps them out,
// one req/gnt (write) or req/rvalid (read) transaction per word, with a request watchdog.
module ispm_loader #(
  parameter int INDEX_WIDTH    = 12,
  parameter int TAG_WIDTH      = 2,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              cmd_valid_i,
  output logic                              cmd_ready_o,
  input  logic                              cmd_write_i,
  input  logic [INDEX_WIDTH+TAG_WIDTH-1:0]  cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]              cmd_len_i,
  input  logic                              wr_valid_i,
  output logic                              wr_ready_o,
  input  logic [63:0]                       wr_data_i,
  input  logic [7:0]                        wr_be_i,
  output logic                              rd_valid_o,
  input  logic                              rd_ready_i,
  output logic [63:0]                       rd_data_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o,
  output logic                              spm_data_req_o,
  output logic [INDEX_WIDTH-1:0]            spm_address_index_o,
  output logic [TAG_WIDTH-1:0]              spm_address_tag_o,
  output logic [63:0]                       spm_data_wdata_o,
  output logic                              spm_data_we_o,
  output logic [7:0]                        spm_data_be_o,
  input  logic                              spm_data_gnt_i,
  input  logic                              spm_data_rvalid_i,
  input  logic [63:0]                       spm_data_rdata_i
);

  localparam int AW  = INDEX_WIDTH + TAG_WIDTH;
  localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WDW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    IDLE, WR_FETCH, WR_REQ, RD_REQ, RD_OUT, DONE
  } state_t;

  state_t               state, state_n;
  logic [AW-1:0]        addr_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [63:0]          wdata_q;
  logic [7:0]           be_q;
  logic [63:0]          rdata_q;
  logic [WDW-1:0]       wdog_q;
  logic                 abort_q;

  logic in_req, wr_cpl, rd_cpl, rd_acc, advance, last, timeout;

  assign in_req  = (state == WR_REQ) || (state == RD_REQ);
  assign wr_cpl  = (state == WR_REQ) && spm_data_gnt_i;
  assign rd_cpl  = (state == RD_REQ) && spm_data_rvalid_i;
  assign rd_acc  = (state == RD_OUT) && rd_ready_i;
  assign advance = wr_cpl || rd_acc;
  assign last    = (rem_q == LEN_WIDTH'(1));
  // Abort only when the watchdog is enabled and this cycle brings no completion.
  assign timeout = (TIMEOUT_CYCLES != 0) && in_req && !wr_cpl && !rd_cpl && (wdog_q == WD_LAST);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (cmd_valid_i) begin
                  if (cmd_len_i == '0)  state_n = DONE;
                  else if (cmd_write_i) state_n = WR_FETCH;
                  else                  state_n = RD_REQ;
                end
      WR_FETCH: if (wr_valid_i) state_n = WR_REQ;
      WR_REQ:   if (wr_cpl)       state_n = last ? DONE : WR_FETCH;
                else if (timeout) state_n = DONE;
      RD_REQ:   if (rd_cpl)       state_n = RD_OUT;
                else if (timeout) state_n = DONE;
      RD_OUT:   if (rd_acc) state_n = last ? DONE : RD_REQ;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      wdog_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && cmd_valid_i) begin
        addr_q  <= cmd_addr_i & ~AW'(7);
        rem_q   <= cmd_len_i;
        abort_q <= 1'b0;
      end
      if (state == WR_FETCH && wr_valid_i) begin
        wdata_q <= wr_data_i;
        be_q    <= wr_be_i;
      end
      if (rd_cpl) rdata_q <= spm_data_rdata_i;
      if (advance) begin
        addr_q <= addr_q + AW'(8);
        rem_q  <= rem_q - LEN_WIDTH'(1);
      end
      // Outside a request the counter sits at 0, so each request starts a fresh count.
      if (in_req) wdog_q <= wdog_q + WDW'(1);
      else        wdog_q <= '0;
      if (timeout) abort_q <= 1'b1;
    end
  end

  assign cmd_ready_o         = (state == IDLE);
  assign wr_ready_o          = (state == WR_FETCH);
  assign rd_valid_o          = (state == RD_OUT);
  assign rd_data_o           = rdata_q;
  assign busy_o              = (state != IDLE);
  assign done_o              = (state == DONE);
  assign err_o               = (state == DONE) && abort_q;
  assign spm_data_req_o      = in_req;
  assign spm_address_index_o = addr_q[INDEX_WIDTH-1:0];
  assign spm_address_tag_o   = addr_q[INDEX_WIDTH +: TAG_WIDTH];
  assign spm_data_we_o       = (state == WR_REQ);
  assign spm_data_wdata_o    = (state == WR_REQ) ? wdata_q : 64'h0;
  assign spm_data_be_o       = (state == WR_REQ) ? be_q : (state == RD_REQ) ? 8'hFF : 8'h00;

endmodule
